hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS pipeline; it handles every hazard the forwarding unit cannot resolve. It detects load-use dependencies and inserts a single bubble. It flushes the fetched instruction on a taken branch resolved in ID. It freezes the whole pipeline while the data memory holds off a MEM-stage access, and raises a sticky timeout error if the memory never answers. It also keeps a saturating stall-cycle performance counter.

## Interface
- MAX_WAIT, 16, consecutive memory-stall cycles tolerated before timeout (≥2)
- CNT_W, 16, width of stall performance counter

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ID_Rs, ID_Rt  in  5  source registers of instruction in ID
- ID_useRt  in  1  instruction in ID reads Rt (R-type, store, beq/bne)
- EX_Rt  in  5  destination register of instruction in EX (load target)
- EX_memRead  in  1  instruction in EX is a load
- ID_branchTaken  in  1  branch in ID resolved taken this cycle
- MEM_memReq  in  1  instruction in MEM accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- pcWrite  out  1  PC may update
- IF_ID_write  out  1  IF/ID register may load
- IF_ID_flush  out  1  IF/ID loads a NOP
- ID_EX_write  out  1  ID/EX register may load
- ID_EX_bubble  out  1  ID/EX loads a NOP (control zeroed)
- EX_MEM_write  out  1  EX/MEM register may load
- MEM_WB_bubble  out  1  MEM/WB loads a NOP
- memTimeout  out  1  sticky timeout error
- stallCount  out  CNT_W  cycles with pcWrite=0, saturating

## Operation
- States: RUN, WAIT, TIMEOUT. Enable and bubble outputs are combinational from state and current inputs. State, waitCnt and stallCount are registered.
- memStall = MEM_memReq && !dmem_ready.
- loadUse = EX_memRead && EX_Rt≠0 && (EX_Rt==ID_Rs || (ID_useRt && EX_Rt==ID_Rt)).
- Default (no hazard): all write enables 1, all bubbles/flush 0.
- Priority, highest first: TIMEOUT > memStall > loadUse > ID_branchTaken.
- Freeze (TIMEOUT, or memStall in RUN/WAIT):
  - pcWrite, IF_ID_write, ID_EX_write and EX_MEM_write are 0.
  - MEM_WB_bubble is 1.
  - IF_ID_flush and ID_EX_bubble are 0. loadUse and branch are ignored; they re-evaluate after release because the ID/EX contents are held.
- loadUse (no freeze): pcWrite=0, IF_ID_write=0, ID_EX_bubble=1. Other enables stay 1. EX_Rt==0 never stalls.
- ID_branchTaken (no freeze, no loadUse): IF_ID_flush=1. PC updates to the target.
- Transitions:
  - RUN→WAIT on a memStall edge.
  - WAIT→RUN on the first edge with dmem_ready=1 or MEM_memReq=0.
  - WAIT→TIMEOUT on the edge ending the MAX_WAIT-th consecutive memStall cycle.
  - TIMEOUT is left only by reset.
- waitCnt counts consecutive memStall cycles. It is cleared whenever memStall=0.
- stallCount increments on each edge where pcWrite=0 and holds at 2^CNT_W−1.

## Timing
- Reset (rst=0, asynchronous):
  - State is RUN; waitCnt and stallCount are 0; memTimeout is 0.
  - Outputs take their default values immediately: enables 1, bubbles 0.
- Stall and flush outputs respond in the same cycle as their cause; there is no pipeline latency.
- A load-use stall lasts exactly 1 cycle. On the next edge the load moves to MEM and EX holds a bubble, so loadUse drops naturally.
- Memory freeze lasts exactly the number of cycles with ready low. Release happens in the cycle dmem_ready=1 is seen, and that cycle has normal enables.
- memTimeout goes high on the edge after MAX_WAIT consecutive stalled cycles and stays high. The pipeline stays frozen.
- A loadUse coincident with memStall produces no bubble during the freeze. The bubble follows on the first unfrozen cycle.
- Reset asserted mid-WAIT or in TIMEOUT returns to RUN at once.

## Test plan
- lw $5 in EX (EX_memRead=1, EX_Rt=5), ID_Rs=5 → 1 cycle of pcWrite=0, IF_ID_write=0, ID_EX_bubble=1; stallCount 0→1; next cycle all defaults.
- EX_Rt=0 with EX_memRead=1 and ID_Rs=0 → no stall. EX_Rt=7, ID_Rt=7, ID_useRt=0 → no stall; with ID_useRt=1 → stall.
- ID_branchTaken=1 with no hazard → IF_ID_flush=1 for 1 cycle, pcWrite=1. With loadUse also true → stall only, flush=0.
- MEM_memReq=1, dmem_ready low 3 cycles then high (MAX_WAIT=16) → 3 frozen cycles with MEM_WB_bubble=1, a simultaneous loadUse gives no bubble until release; stallCount=3; memTimeout stays 0.
- dmem_ready held low with MAX_WAIT=4 → memTimeout=1 after the 4th edge. The pipeline stays frozen even after ready rises. rst=0 clears it and returns to RUN defaults immediately.
- CNT_W=4, hold a freeze for 20 cycles → stallCount saturates at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use bubble, ID branch flush, dmem freeze + sticky timeout.
// Zero latency: all enables/bubbles are combinational from state and inputs; state, wait counter and stall counter are registered.
module hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_useRt,
    input  logic [4:0]       EX_Rt,
    input  logic             EX_memRead,
    input  logic             ID_branchTaken,
    input  logic             MEM_memReq,
    input  logic             dmem_ready,
    output logic             pcWrite,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_write,
    output logic             MEM_WB_bubble,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCount
);

    localparam int WCNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0]   stallCount_q, stallCount_d;

    logic mem_stall;
    logic load_use;
    logic freeze;
    logic rs_hit;
    logic rt_hit;

    assign mem_stall = MEM_memReq && !dmem_ready;
    assign rs_hit    = (EX_Rt == ID_Rs);
    assign rt_hit    = ID_useRt && (EX_Rt == ID_Rt);
    // Register $0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use  = EX_memRead && (EX_Rt != 5'd0) && (rs_hit || rt_hit);
    assign freeze    = (state_q == ST_TIMEOUT) || mem_stall;

    always_comb begin
        pcWrite       = 1'b1;
        IF_ID_write   = 1'b1;
        IF_ID_flush   = 1'b0;
        ID_EX_write   = 1'b1;
        ID_EX_bubble  = 1'b0;
        EX_MEM_write  = 1'b1;
        MEM_WB_bubble = 1'b0;
        if (freeze) begin
            // ID/EX is held, so a pending load-use or branch re-evaluates after release.
            pcWrite       = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_write  = 1'b0;
            MEM_WB_bubble = 1'b1;
        end else if (load_use) begin
            pcWrite      = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
        end else if (ID_branchTaken) begin
            IF_ID_flush  = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        waitCnt_d = '0;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d   = ST_WAIT;
                    waitCnt_d = WCNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!mem_stall) begin
                    state_d = ST_RUN;
                end else if (waitCnt_q >= WAIT_LAST) begin
                    state_d   = ST_TIMEOUT;
                    waitCnt_d = waitCnt_q;
                end else begin
                    waitCnt_d = waitCnt_q + WCNT_W'(1);
                end
            end
            ST_TIMEOUT: begin
                waitCnt_d = mem_stall ? waitCnt_q : '0;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stallCount_d = stallCount_q;
        if (!pcWrite && (stallCount_q != {CNT_W{1'b1}})) begin
            stallCount_d = stallCount_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            waitCnt_q    <= '0;
            stallCount_q <= '0;
        end else begin
            state_q      <= state_d;
            waitCnt_q    <= waitCnt_d;
            stallCount_q <= stallCount_d;
        end
    end

    assign memTimeout = (state_q == ST_TIMEOUT);
    assign stallCount = stallCount_q;

endmodule
